// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
// Holds the controller state enum and the default widths.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int PSC_W_DEF = 4;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake bundle for the countdown timer.
// master: load_valid/load_value/prescale/auto_reload out, load_ready in.
interface countdown_timer_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic [PSC_W-1:0] prescale;
    logic             auto_reload;

    modport master (
        output load_valid,
        output load_value,
        output prescale,
        output auto_reload,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  prescale,
        input  auto_reload,
        output load_ready
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: one tick every psc+1 enabled cycles.
// Ports: clk, reset, clear (phase to 0), en, psc; tick (combinational).
module tick_gen #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] phase_q;

    assign tick = en && (phase_q == psc);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase_q <= '0;
        end else if (en) begin
            phase_q <= tick ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with prescaler, one-shot/periodic modes.
// Ports: clk, reset, load (slave bundle), start, stop; count, busy, tc.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave load,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             busy_q;
    logic             ready_q;
    logic             tick;

    // Phase is held at 0 outside RUN, so every entry into RUN starts fresh.
    tick_gen #(.PSC_W(PSC_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != RUN),
        .en    (state_q == RUN),
        .psc   (psc_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        psc_d    = psc_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load.load_valid) begin
                    count_d  = load.load_value;
                    reload_d = load.load_value;
                    psc_d    = load.prescale;
                    mode_d   = load.auto_reload;
                    state_d  = LOADED;
                end
            end
            LOADED: begin
                if (load.load_valid) begin
                    count_d  = load.load_value;
                    reload_d = load.load_value;
                    psc_d    = load.prescale;
                    mode_d   = load.auto_reload;
                end else if (start) begin
                    if (count_q == '0) begin
                        tc_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = LOADED;
                end else if (tick) begin
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            psc_q    <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            psc_q    <= psc_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
            ready_q  <= (state_d != RUN);
        end
    end

    assign count           = count_q;
    assign busy            = busy_q;
    assign tc              = tc_q;
    assign load.load_ready = ready_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8, count register width.
REQ-002 Parameter PSC_W, default 4, prescaler width.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 load_valid  input  1  load request.
REQ-006 load_ready  output  1  load may be accepted this cycle.
REQ-007 load_value  input  WIDTH  initial/reload count.
REQ-008 prescale  input  PSC_W  tick divider P; one tick every P+1 cycles.
REQ-009 auto_reload  input  1  1 = periodic mode, 0 = one-shot.
REQ-010 start  input  1  begin/resume counting.
REQ-011 stop  input  1  pause counting.
REQ-012 count  output  WIDTH  current remaining count.
REQ-013 busy  output  1  high while in RUN.
REQ-014 tc  output  1  terminal-count pulse, exactly one cycle wide.

Function
REQ-015 States SHALL be IDLE, LOADED and RUN; busy = (state==RUN).
REQ-016 load_ready SHALL be 1 in IDLE and LOADED and 0 in RUN; load_valid in RUN is ignored.
REQ-017 Load accept (load_valid & load_ready) SHALL register count<=load_value, reload<=load_value, psc<=prescale and mode<=auto_reload, then enter LOADED.
REQ-018 In LOADED, start SHALL enter RUN with the prescaler phase cleared to 0.
REQ-019 start in IDLE SHALL be ignored.
REQ-020 In RUN, the phase counter SHALL increment each cycle; when phase==psc, it SHALL generate a tick and clear to 0.
REQ-021 Each tick SHALL decrement count by 1, with no wrap below 0.
REQ-022 On a tick with count==1 and mode=0: count<=0, tc=1, next state IDLE.
REQ-023 On a tick with count==1 and mode=1: count<=reload, tc=1, stay RUN, phase restarts at 0.
REQ-024 Latency: with count N and prescale P, tc SHALL be asserted at clock edge N*(P+1) after the edge sampling start.
REQ-025 start while count==0 in LOADED SHALL pulse tc the next cycle and return to IDLE, with no decrement.
REQ-026 stop in RUN SHALL enter LOADED holding count; start later resumes from the held count with phase cleared.
REQ-027 stop and start in the same cycle: stop wins.
REQ-028 stop on a tick cycle: stop wins; no decrement and no tc.
REQ-029 Load accept and start in the same cycle in LOADED: the load wins and start is ignored.
REQ-030 tc SHALL be registered and is 0 in every cycle not named above.

Reset
REQ-031 reset SHALL force state=IDLE, count=0, reload=0, psc=0, mode=0, phase=0, tc=0, busy=0 and load_ready=1 on the next edge, overriding all inputs.
REQ-032 reset during RUN SHALL abort counting with no tc pulse.

Structure
REQ-033 Package timer_pkg SHALL hold the state enum (IDLE/LOADED/RUN) and the default WIDTH and PSC_W constants.
REQ-034 The prescaler SHALL be a sub-module tick_gen (inputs: clk, reset, clear, en, psc; output: tick).
REQ-035 The block SHALL be fully synthesizable and use no delays in assignments.

Verification
REQ-036 Load 5, P=0, one-shot, start -> tc at edge 5, count sequence 4,3,2,1,0, then IDLE.
REQ-037 Load 3, P=2, auto_reload=1, start -> tc at edges 9, 18 and 27; count reloads to 3 each time; busy stays 1.
REQ-038 Load 4, P=1, start; stop at edge 3; hold 5 cycles; start -> count frozen at 3 while paused; tc 6 edges after resume.
REQ-039 Load 0, start -> tc the next cycle, state IDLE, count stays 0.
REQ-040 Load 8, P=3, start; reset at edge 10 -> all outputs at reset values next cycle; no tc ever seen.
REQ-041 load_valid in RUN ignored; stop+start in the same cycle pauses; stop on a tick cycle gives no decrement.
